// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared register-file types and sizes for the RV32I core.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0] regaddr_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/wb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arb
// Description : Two-requester round-robin arbiter. req[0]=ALU, req[1]=LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arb
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e r_last_grant;

    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Under contention the side that did not win last time goes first.
                2'b11:   gnt = (r_last_grant == WB_LSU) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= WB_ALU;
        end else if (|gnt) begin
            r_last_grant <= gnt[1] ? WB_LSU : WB_ALU;
        end
    end

endmodule : wb_rr_arb
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the regfile write port between ALU and LSU writeback,
//               tracks in-flight loads and flags decode RAW/WAW hazards.
//               Optional macro RF_WB_BYPASS_EN adds write-stage bypass ports.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS,
    parameter int AW_P    = $clog2(NREGS_P)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW_P-1:0]   alu_rd,
    input  logic [XLEN_P-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [AW_P-1:0]   lsu_rd,
    input  logic [XLEN_P-1:0] lsu_data,
    input  logic              ld_issue,
    input  logic [AW_P-1:0]   ld_issue_rd,
    input  logic [AW_P-1:0]   dec_rs1,
    input  logic [AW_P-1:0]   dec_rs2,
    input  logic [AW_P-1:0]   dec_rd,
    input  logic              dec_rs1_en,
    input  logic              dec_rs2_en,
    input  logic              dec_rd_en,
    output logic              hazard,
    output logic [AW_P-1:0]   rf_rd,
    output logic              rf_rd_en,
    output logic [XLEN_P-1:0] rf_rd_data
`ifdef RF_WB_BYPASS_EN
    ,
    output logic              byp_rs1_hit,
    output logic              byp_rs2_hit,
    output logic [XLEN_P-1:0] byp_data
`endif
);

    localparam logic [AW_P-1:0] c_x0 = '0;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic [AW_P-1:0]   w_acc_rd;
    logic [XLEN_P-1:0] w_acc_data;
    wb_src_e           w_acc_src;

    logic              r_wb_en;
    logic [AW_P-1:0]   r_wb_rd;
    logic [XLEN_P-1:0] r_wb_data;
    wb_src_e           r_wb_src;

    logic [NREGS_P-1:0] r_busy;
    logic [NREGS_P-1:0] w_busy_nxt;
    logic               w_busy_set;
    logic               w_busy_clr;
    logic               w_sb_hazard;

    assign w_req = {lsu_valid, alu_valid};

    wb_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .gnt   (w_gnt)
    );

    assign alu_ready = w_gnt[0];
    assign lsu_ready = w_gnt[1];

    always_comb begin
        w_acc_rd   = alu_rd;
        w_acc_data = alu_data;
        w_acc_src  = WB_ALU;
        if (w_gnt[1]) begin
            w_acc_rd   = lsu_rd;
            w_acc_data = lsu_data;
            w_acc_src  = WB_LSU;
        end
    end

    // Writes to x0 are accepted but never reach the regfile.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_src  <= WB_ALU;
        end else begin
            r_wb_en <= (|w_gnt) && (w_acc_rd != c_x0);
            if (|w_gnt) begin
                r_wb_rd   <= w_acc_rd;
                r_wb_data <= w_acc_data;
                r_wb_src  <= w_acc_src;
            end
        end
    end

    assign rf_rd_en   = r_wb_en;
    assign rf_rd      = r_wb_rd;
    assign rf_rd_data = r_wb_data;

    assign w_busy_clr = r_wb_en && (r_wb_src == WB_LSU);
    assign w_busy_set = ld_issue && (ld_issue_rd != c_x0);

    // Set is applied after clear so a same-index collision keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_busy_clr) begin
            w_busy_nxt[r_wb_rd] = 1'b0;
        end
        if (w_busy_set) begin
            w_busy_nxt[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign w_sb_hazard = (dec_rs1_en && (dec_rs1 != c_x0) && r_busy[dec_rs1])
                       | (dec_rs2_en && (dec_rs2 != c_x0) && r_busy[dec_rs2])
                       | (dec_rd_en  && (dec_rd  != c_x0) && r_busy[dec_rd]);

`ifdef RF_WB_BYPASS_EN
    assign byp_rs1_hit = r_wb_en && dec_rs1_en && (dec_rs1 != c_x0) && (r_wb_rd == dec_rs1);
    assign byp_rs2_hit = r_wb_en && dec_rs2_en && (dec_rs2 != c_x0) && (r_wb_rd == dec_rs2);
    assign byp_data    = r_wb_data;
    assign hazard      = w_sb_hazard;
`else
    logic w_wb_hazard;

    // Without bypass, decode waits until the staged write has committed.
    assign w_wb_hazard = r_wb_en && (r_wb_rd != c_x0)
                       && ((dec_rs1_en && (dec_rs1 == r_wb_rd))
                        || (dec_rs2_en && (dec_rs2 == r_wb_rd)));
    assign hazard = w_sb_hazard | w_wb_hazard;
`endif

`ifndef SYNTHESIS
    a_ld_issue_not_busy : assert property (@(posedge clk) disable iff (!reset)
        w_busy_set |-> (!r_busy[ld_issue_rd] || (w_busy_clr && (r_wb_rd == ld_issue_rd))));
`endif

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Self-checking bench for rf_wb_arbiter with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;
    import rv32i_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, lsu_valid, ld_issue;
    logic            alu_ready, lsu_ready;
    logic [AW-1:0]   alu_rd, lsu_rd, ld_issue_rd;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic [AW-1:0]   dec_rs1, dec_rs2, dec_rd;
    logic            dec_rs1_en, dec_rs2_en, dec_rd_en;
    logic            hazard;
    logic [AW-1:0]   rf_rd;
    logic            rf_rd_en;
    logic [XLEN-1:0] rf_rd_data;
`ifdef RF_WB_BYPASS_EN
    logic            byp_rs1_hit, byp_rs2_hit;
    logic [XLEN-1:0] byp_data;
`endif

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_rs1_en  (dec_rs1_en),
        .dec_rs2_en  (dec_rs2_en),
        .dec_rd_en   (dec_rd_en),
        .hazard      (hazard),
        .rf_rd       (rf_rd),
        .rf_rd_en    (rf_rd_en),
        .rf_rd_data  (rf_rd_data)
`ifdef RF_WB_BYPASS_EN
        ,
        .byp_rs1_hit (byp_rs1_hit),
        .byp_rs2_hit (byp_rs2_hit),
        .byp_data    (byp_data)
`endif
    );

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        int              cyc;
    } wb_exp_t;

    wb_exp_t q_exp[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference state, derived from the behavioural description
    logic            m_last;
    logic [31:0]     m_busy;
    logic            m_wb_en, m_wb_src;
    logic [AW-1:0]   m_wb_rd;
    logic [XLEN-1:0] m_wb_data;
    logic            m_ga, m_gl;

    // Observations from the most recent cycle
    logic            s_alu_ready, s_lsu_ready, s_hazard, s_rf_en;
    logic [AW-1:0]   s_rf_rd;
    logic [XLEN-1:0] s_rf_data;
`ifdef RF_WB_BYPASS_EN
    logic            s_byp1;
    logic [XLEN-1:0] s_byp_data;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        ld_issue  = 1'b0;
    endtask

    task automatic set_dec(input logic [AW-1:0] rs1, input logic e1,
                           input logic [AW-1:0] rs2, input logic e2,
                           input logic [AW-1:0] rd,  input logic e3);
        dec_rs1 = rs1; dec_rs1_en = e1;
        dec_rs2 = rs2; dec_rs2_en = e2;
        dec_rd  = rd;  dec_rd_en  = e3;
    endtask

    // Checks one cycle at the negedge, then advances the reference at the posedge.
    task automatic run_cycle();
        logic        exp_haz, exp_en;
        logic [31:0] nb;
        wb_exp_t     e;
        @(negedge clk);
        m_ga = 1'b0;
        m_gl = 1'b0;
        if (reset) begin
            if (alu_valid && lsu_valid) begin
                if (m_last) m_ga = 1'b1;
                else        m_gl = 1'b1;
            end else begin
                m_ga = alu_valid;
                m_gl = lsu_valid;
            end
        end
        check("alu_ready", {63'd0, alu_ready}, {63'd0, m_ga});
        check("lsu_ready", {63'd0, lsu_ready}, {63'd0, m_gl});

        exp_haz = (dec_rs1_en && dec_rs1 != 0 && m_busy[dec_rs1])
                | (dec_rs2_en && dec_rs2 != 0 && m_busy[dec_rs2])
                | (dec_rd_en  && dec_rd  != 0 && m_busy[dec_rd]);
`ifdef RF_WB_BYPASS_EN
        check("byp_rs1_hit", {63'd0, byp_rs1_hit},
              {63'd0, m_wb_en && dec_rs1_en && dec_rs1 != 0 && dec_rs1 == m_wb_rd});
        check("byp_rs2_hit", {63'd0, byp_rs2_hit},
              {63'd0, m_wb_en && dec_rs2_en && dec_rs2 != 0 && dec_rs2 == m_wb_rd});
        if (m_wb_en) check("byp_data", {32'd0, byp_data}, {32'd0, m_wb_data});
        s_byp1     = byp_rs1_hit;
        s_byp_data = byp_data;
`else
        exp_haz = exp_haz | (m_wb_en && m_wb_rd != 0 &&
                  ((dec_rs1_en && dec_rs1 == m_wb_rd) || (dec_rs2_en && dec_rs2 == m_wb_rd)));
`endif
        check("hazard", {63'd0, hazard}, {63'd0, exp_haz});

        exp_en = (q_exp.size() > 0) && (q_exp[0].cyc == cyc);
        check("rf_rd_en", {63'd0, rf_rd_en}, {63'd0, exp_en});
        if (rf_rd_en && exp_en) begin
            e = q_exp.pop_front();
            check("rf_rd", {59'd0, rf_rd}, {59'd0, e.rd});
            check("rf_rd_data", {32'd0, rf_rd_data}, {32'd0, e.data});
        end

        s_alu_ready = alu_ready;
        s_lsu_ready = lsu_ready;
        s_hazard    = hazard;
        s_rf_en     = rf_rd_en;
        s_rf_rd     = rf_rd;
        s_rf_data   = rf_rd_data;

        if (m_ga && alu_rd != 0) q_exp.push_back('{rd: alu_rd, data: alu_data, cyc: cyc + 1});
        if (m_gl && lsu_rd != 0) q_exp.push_back('{rd: lsu_rd, data: lsu_data, cyc: cyc + 1});

        @(posedge clk);
        if (!reset) begin
            m_busy  = '0;
            m_last  = 1'b0;
            m_wb_en = 1'b0;
            q_exp.delete();
        end else begin
            nb = m_busy;
            if (m_wb_en && m_wb_src) nb[m_wb_rd] = 1'b0;
            if (ld_issue && ld_issue_rd != 0) nb[ld_issue_rd] = 1'b1;
            m_busy = nb;
            if (m_ga || m_gl) begin
                m_last    = m_gl;
                m_wb_src  = m_gl;
                m_wb_rd   = m_gl ? lsu_rd : alu_rd;
                m_wb_data = m_gl ? lsu_data : alu_data;
                m_wb_en   = (m_wb_rd != 0);
            end else begin
                m_wb_en = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        logic [3:0]    gseq;
        logic [AW-1:0] r;
        m_busy = '0; m_last = 1'b0; m_wb_en = 1'b0; m_wb_src = 1'b0;
        m_wb_rd = '0; m_wb_data = '0;
        reset = 1'b0;
        idle();
        alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0; ld_issue_rd = '0;
        set_dec('0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Reset state
        run_cycle();
        run_cycle();
        check("rst_rf_rd_en", {63'd0, rf_rd_en}, 64'd0);
        check("rst_rf_rd", {59'd0, rf_rd}, 64'd0);
        check("rst_rf_rd_data", {32'd0, rf_rd_data}, 64'd0);
        check("rst_ready", {62'd0, s_alu_ready, s_lsu_ready}, 64'd0);
        reset = 1'b1;

        // Lone ALU request
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        run_cycle();
        check("lone_ready", {63'd0, s_alu_ready}, 64'd1);
        idle();
        run_cycle();
        check("lone_en", {63'd0, s_rf_en}, 64'd1);
        check("lone_rd", {59'd0, s_rf_rd}, 64'd5);
        check("lone_data", {32'd0, s_rf_data}, 64'hDEADBEEF);

        // Contention after an ALU grant: LSU, ALU, LSU, ALU
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2B2B2B2;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            gseq[i] = s_lsu_ready;
            check("contend_onehot", {62'd0, s_alu_ready, s_lsu_ready}, s_lsu_ready ? 64'd1 : 64'd2);
        end
        check("contend_order", {60'd0, gseq}, 64'b0101);
        idle();
        run_cycle();

        // Scoreboard RAW on x7
        set_dec(5'd7, 1'b1, '0, 1'b0, '0, 1'b0);
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        run_cycle();
        ld_issue = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle();
        check("sb_wait", {63'd0, s_hazard}, 64'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77777777;
        run_cycle();
        idle();
        run_cycle();
        check("sb_staged", {63'd0, s_hazard}, 64'd1);
        run_cycle();
        check("sb_clear", {63'd0, s_hazard}, 64'd0);

        // x0 handling
        set_dec('0, 1'b0, '0, 1'b0, '0, 1'b0);
        alu_valid = 1'b1; alu_rd = '0; alu_data = 32'h1234;
        run_cycle();
        check("x0_ready", {63'd0, s_alu_ready}, 64'd1);
        idle();
        run_cycle();
        check("x0_no_write", {63'd0, s_rf_en}, 64'd0);
        ld_issue = 1'b1; ld_issue_rd = '0;
        set_dec('0, 1'b0, '0, 1'b1, '0, 1'b0);
        run_cycle();
        ld_issue = 1'b0;
        run_cycle();
        check("x0_no_hazard", {63'd0, s_hazard}, 64'd0);

        // Set/clear collision on x3
        set_dec('0, 1'b0, '0, 1'b0, '0, 1'b0);
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        run_cycle();
        ld_issue = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
        run_cycle();
        idle();
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        run_cycle();
        ld_issue = 1'b0;
        set_dec(5'd3, 1'b1, '0, 1'b0, '0, 1'b0);
        run_cycle();
        check("collide_busy", {63'd0, s_hazard}, 64'd1);
        set_dec('0, 1'b0, '0, 1'b0, '0, 1'b0);
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h333;
        run_cycle();
        idle();
        run_cycle();
        run_cycle();

        // Staged write of x9 seen from decode
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
        run_cycle();
        idle();
        set_dec(5'd9, 1'b1, '0, 1'b0, '0, 1'b0);
        run_cycle();
`ifdef RF_WB_BYPASS_EN
        check("byp_hit", {63'd0, s_byp1}, 64'd1);
        check("byp_value", {32'd0, s_byp_data}, 64'h55);
`else
        check("staged_hazard", {63'd0, s_hazard}, 64'd1);
`endif
        set_dec('0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Reset with a staged write and busy[4]
        ld_issue = 1'b1; ld_issue_rd = 5'd4;
        run_cycle();
        ld_issue = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        run_cycle();
        idle();
        set_dec(5'd4, 1'b1, '0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        run_cycle();
        reset = 1'b1;
        run_cycle();
        check("rst_mid_en", {63'd0, s_rf_en}, 64'd0);
        check("rst_mid_hazard", {63'd0, s_hazard}, 64'd0);

        // Random traffic with held requests and legal load issue
        for (int i = 0; i < 300; i++) begin
            if (!alu_valid || m_ga) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = AW'($urandom_range(0, 15));
                alu_data  = $urandom;
            end
            if (!lsu_valid || m_gl) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rd    = AW'($urandom_range(0, 15));
                lsu_data  = $urandom;
            end
            r = AW'($urandom_range(0, 15));
            ld_issue    = ($urandom_range(0, 3) == 0) &&
                          (!m_busy[r] || (m_wb_en && m_wb_src && m_wb_rd == r));
            ld_issue_rd = r;
            set_dec(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            run_cycle();
        end
        idle();
        for (int i = 0; i < 3; i++) run_cycle();
        check("sb_drain", 64'(q_exp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rf_wb_arbiter
`default_nettype wire
